arb_mux: RTL and testbench

Registered, handshaked N-to-1 multiplexer that arbitrates among `CHANNELS` valid/ready input streams of `WIDTH` bits and forwards one word per cycle to a single output register. It replaces the combinational decoder-driven select mux wherever sources are independent streaming producers that need arbitration instead of an externally driven select. It sits between multiple producers and a single shared consumer, such as a bus or FIFO write port.

---
 rtl/arb_mux_pkg.sv | 23 ++
 rtl/arb_mux_if.sv | 37 +++
 rtl/arb_mux_rr_arbiter.sv | 69 ++++++
 rtl/arb_mux.sv | 77 +++++++
 tb/tb_arb_mux.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arb_mux arbitrated multiplexer.
// Grant vectors are carried at a fixed maximum width so helpers work for any channel count.
package arb_mux_pkg;

    localparam int MAX_CHANNELS = 32;
    localparam int IDX_W        = $clog2(MAX_CHANNELS);

    typedef logic [MAX_CHANNELS-1:0] grant_vec_t;
    typedef logic [IDX_W-1:0]        grant_idx_t;

    // OR-reduces the indices of set bits; exact for one-hot or all-zero inputs.
    function automatic grant_idx_t onehot_to_idx(input grant_vec_t oh);
        grant_idx_t idx;
        idx = '0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (oh[i]) begin
                idx = idx | grant_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Handshake bundle between arb_mux, its producers and its consumer.
// slave is the arb_mux view; master is the producer/consumer (or bench) view.
interface arb_mux_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    localparam int ADDR_SIZE = $clog2(CHANNELS);

    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH*CHANNELS-1:0] in;
    logic [WIDTH-1:0]          out;
    logic                      out_valid;
    logic                      out_ready;
    logic [ADDR_SIZE-1:0]      out_sel;

    modport slave (
        input  in_valid,
        input  in,
        input  out_ready,
        output in_ready,
        output out,
        output out_valid,
        output out_sel
    );

    modport master (
        output in_valid,
        output in,
        output out_ready,
        input  in_ready,
        input  out,
        input  out_valid,
        input  out_sel
    );

endinterface

// File: rtl/arb_mux_rr_arbiter.sv
// Grant generator for arb_mux: round-robin when ARB_MUX_RR_EN is defined,
// otherwise fixed priority (lowest index wins) with no pointer state.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    localparam int ADDR_SIZE = $clog2(CHANNELS)
) (
`ifdef ARB_MUX_RR_EN
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
`endif
    input  logic [CHANNELS-1:0]  req,
    output logic [CHANNELS-1:0]  grant,
    output logic [ADDR_SIZE-1:0] grant_idx
);

`ifdef ARB_MUX_RR_EN
    logic [ADDR_SIZE-1:0] ptr_reg;
    logic [ADDR_SIZE-1:0] ptr_next;
    logic [ADDR_SIZE:0]   slot;
    logic                 found;

    // Search starts at the pointer and wraps modulo CHANNELS, so non-power-of-two counts work.
    always_comb begin
        grant = '0;
        found = 1'b0;
        slot  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            slot = {1'b0, ptr_reg} + (ADDR_SIZE+1)'(k);
            if (slot >= (ADDR_SIZE+1)'(CHANNELS)) begin
                slot = slot - (ADDR_SIZE+1)'(CHANNELS);
            end
            if (!found && req[slot[ADDR_SIZE-1:0]]) begin
                grant[slot[ADDR_SIZE-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign ptr_next = (grant_idx == ADDR_SIZE'(CHANNELS-1)) ? '0
                                                            : grant_idx + ADDR_SIZE'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else if (load) begin
            ptr_reg <= ptr_next;
        end
    end
`else
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!found && req[k]) begin
                grant[k] = 1'b1;
                found = 1'b1;
            end
        end
    end
`endif

    assign grant_idx = ADDR_SIZE'(onehot_to_idx(grant_vec_t'(grant)));

endmodule

// File: rtl/arb_mux.sv
// Registered, handshaked CHANNELS-to-1 multiplexer with built-in arbitration.
// Define ARB_MUX_RR_EN for round-robin grants; default build is fixed priority.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     enable,
    arb_mux_if.slave bus
);

    localparam int ADDR_SIZE = $clog2(CHANNELS);

    logic                 load;
    logic [CHANNELS-1:0]  grant;
    logic [ADDR_SIZE-1:0] grant_idx;
    logic [WIDTH-1:0]     masked [CHANNELS];
    logic [WIDTH-1:0]     sel_data;

    logic                 out_valid_reg;
    logic [WIDTH-1:0]     out_reg;
    logic [ADDR_SIZE-1:0] out_sel_reg;

    // reset_n gates load so no grant is visible while reset is held.
    assign load = reset_n & enable & (|bus.in_valid) & (~out_valid_reg | bus.out_ready);

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arbiter (
`ifdef ARB_MUX_RR_EN
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
`endif
        .req       (bus.in_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.in_ready = grant & {CHANNELS{load}};

    // AND-OR select driven by the one-hot grant; no dependence on data for ready.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_mask
            assign masked[gi] = bus.in[WIDTH*gi +: WIDTH] & {WIDTH{grant[gi]}};
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sel_data = sel_data | masked[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            out_sel_reg   <= '0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_reg       <= sel_data;
            out_sel_reg   <= grant_idx;
        end else if (out_valid_reg && bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out       = out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_sel   = out_sel_reg;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux (CHANNELS=4, WIDTH=8): directed vectors push expected
// words, a negedge monitor compares whatever the DUT presents on its output register.
module tb_arb_mux;

    localparam int CH = 4;
    localparam int W  = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b0;

    arb_mux_if #(.CHANNELS(CH), .WIDTH(W)) bus();

    arb_mux #(
        .CHANNELS (CH),
        .WIDTH    (W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   vec_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: output register must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (reset_n) begin
            check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            if (bus.out_valid && q.size() != 0) begin
                check("out", 32'(bus.out), 32'(q[0].data));
                check("out_sel", 32'(bus.out_sel), 32'(q[0].sel));
                if (bus.out_ready) begin
                    void'(q.pop_front());
                end
            end
        end
    end

    // Drives one cycle of stimulus; expected ready differs only by arbitration mode.
    task automatic apply(input string name, input logic en, input logic [3:0] valid,
                         input logic ordy, input logic [3:0] rdy_fp, input logic [3:0] rdy_rr,
                         input logic a5 = 1'b0);
        logic [3:0] exp_rdy;
        logic [7:0] d [4];
        exp_t       e;
`ifdef ARB_MUX_RR_EN
        exp_rdy = rdy_rr;
`else
        exp_rdy = rdy_fp;
`endif
        vec_no++;
        for (int i = 0; i < 4; i++) begin
            d[i] = 8'(((vec_no % 16) * 16) + i);
        end
        if (a5) d[2] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            bus.in[8*i +: 8] = d[i];
        end
        enable        = en;
        bus.in_valid  = valid;
        bus.out_ready = ordy;
        @(negedge clk);
        check({name, ".in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
        e.sel  = 2'd0;
        e.data = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                e.sel  = 2'(i);
                e.data = d[i];
            end
        end
        @(posedge clk);
        #1;
        if (exp_rdy != 4'd0) q.push_back(e);
    endtask

    task automatic do_reset(input string name);
        reset_n       = 1'b0;
        enable        = 1'b1;
        bus.in_valid  = 4'($urandom_range(1, 15));
        bus.in        = 32'($urandom);
        bus.out_ready = 1'($urandom);
        #1;
        q.delete();
        check({name, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        check({name, ".out"}, 32'(bus.out), 32'd0);
        check({name, ".out_sel"}, 32'(bus.out_sel), 32'd0);
        check({name, ".in_ready"}, 32'(bus.in_ready), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 4'($urandom_range(1, 15));
            bus.in        = 32'($urandom);
            bus.out_ready = 1'($urandom);
            check({name, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            check({name, ".hold_out_valid"}, 32'(bus.out_valid), 32'd0);
        end
        bus.in_valid = 4'd0;
        reset_n      = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 4'd0;
        bus.in        = 32'd0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset("rst");

        //     name          en  valid    ordy  fixed    round-robin
        apply("a5",          1, 4'b0100, 1, 4'b0100, 4'b0100, 1'b1);
        apply("all0",        1, 4'b1111, 1, 4'b0001, 4'b1000);
        apply("all1",        1, 4'b1111, 1, 4'b0001, 4'b0001);
        apply("all2",        1, 4'b1111, 1, 4'b0001, 4'b0010);
        apply("all3",        1, 4'b1111, 1, 4'b0001, 4'b0100);
        apply("all4",        1, 4'b1111, 1, 4'b0001, 4'b1000);
        apply("v1010_0",     1, 4'b1010, 1, 4'b0010, 4'b0010);
        apply("v1010_1",     1, 4'b1010, 1, 4'b0010, 4'b1000);
        apply("v1010_2",     1, 4'b1010, 1, 4'b0010, 4'b0010);
        repeat (5)
            apply("bp",      1, 4'b1111, 0, 4'b0000, 4'b0000);
        apply("bp_release",  1, 4'b1111, 1, 4'b0001, 4'b0100);
        apply("en_off0",     0, 4'b1111, 1, 4'b0000, 4'b0000);
        apply("en_off1",     0, 4'b1111, 1, 4'b0000, 4'b0000);
        apply("en_on",       1, 4'b1111, 1, 4'b0001, 4'b1000);
        apply("idle",        1, 4'b0000, 1, 4'b0000, 4'b0000);
        apply("pre_rst",     1, 4'b0100, 1, 4'b0100, 4'b0100);

        do_reset("rst_mid");

        apply("post_rst",    1, 4'b1100, 1, 4'b0100, 4'b0100);
        apply("drain",       1, 4'b0000, 1, 4'b0000, 4'b0000);
        apply("load_nordy",  1, 4'b0001, 0, 4'b0001, 4'b0001);
        apply("bp_hold",     1, 4'b0001, 0, 4'b0000, 4'b0000);
        apply("final_drain", 1, 4'b0000, 1, 4'b0000, 4'b0000);
        apply("idle2",       1, 4'b0000, 1, 4'b0000, 4'b0000);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
